sig_collector: RTL and testbench

SIG_COLLECTOR -- requirements
Module: sig_collector

---
 rtl/sig_collector.sv | 120 ++++++++++++
 tb/tb_sig_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sig_collector.sv
// rtl/sig_collector.sv - MISR signature collector with serial MSB-first readout
// Absorbs registered monitor bits for WINDOW cycles, then shifts the signature out.
module sig_collector #(
  parameter int                  INPUTS   = 8,
  parameter int                  SIG_BITS = 16,
  parameter logic [SIG_BITS-1:0] POLY     = 16'h1021,
  parameter int                  WINDOW   = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [INPUTS-1:0] d,
  input  logic              start,
  output logic              q,
  output logic              q_valid,
  output logic              busy,
  output logic              done
);

  localparam int MAXV = (WINDOW > SIG_BITS) ? WINDOW : SIG_BITS;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] CNT_WIN = CW'(WINDOW);
  localparam logic [CW-1:0] CNT_SHL = CW'(SIG_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SIG_BITS-1:0] misr_q, misr_d;
  logic [INPUTS-1:0]   d_r_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [SIG_BITS-1:0] misr_step;
  logic [SIG_BITS-1:0] misr_shift;

  assign misr_step  = (misr_q << 1) ^ (misr_q[SIG_BITS-1] ? POLY : '0) ^ SIG_BITS'(d_r_q);
  assign misr_shift = misr_q << 1;

  // ACCUM runs WINDOW absorb cycles plus one hold cycle that loads the first output bit.
  always_comb begin
    state_d   = state_q;
    misr_d    = misr_q;
    cnt_d     = cnt_q;
    q_d       = 1'b0;
    q_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          misr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ACCUM: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_WIN) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          q_d       = misr_q[SIG_BITS-1];
          q_valid_d = 1'b1;
        end else begin
          misr_d = misr_step;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        misr_d = misr_shift;
        if (cnt_q == CNT_SHL) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          q_d       = misr_shift[SIG_BITS-1];
          q_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      misr_q    <= '0;
      d_r_q     <= '0;
      cnt_q     <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      misr_q    <= misr_d;
      d_r_q     <= d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sig_collector.sv
// tb/tb_sig_collector.sv - randomized bench for sig_collector against a run-timeline model
// Three instances share clk/resetn/start/d: (1,4,3,W=4), (1,4,3,W=5) and the defaults.
module tb_sig_collector;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] d = 8'h00;
  logic       q_o[3];
  logic       qv_o[3];
  logic       busy_o[3];
  logic       done_o[3];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sig_collector #(.INPUTS(1), .SIG_BITS(4), .POLY(4'h3), .WINDOW(4)) u_w4 (
    .clk(clk), .resetn(resetn), .d(d[0:0]), .start(start),
    .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  sig_collector #(.INPUTS(1), .SIG_BITS(4), .POLY(4'h3), .WINDOW(5)) u_w5 (
    .clk(clk), .resetn(resetn), .d(d[0:0]), .start(start),
    .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  sig_collector u_def (
    .clk(clk), .resetn(resetn), .d(d), .start(start),
    .q(q_o[2]), .q_valid(qv_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int win(input int i);
    return (i == 0) ? 4 : (i == 1) ? 5 : 256;
  endfunction
  function automatic int sbits(input int i);
    return (i < 2) ? 4 : 16;
  endfunction
  function automatic int poly(input int i);
    return (i < 2) ? 3 : 'h1021;
  endfunction
  function automatic int dmask(input int i);
    return (i < 2) ? 1 : 255;
  endfunction

  // mt = cycles since the accepting start edge (-1 when idle); ds = absorbed samples.
  int mt[3] = '{-1, -1, -1};
  int ds[3][256];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) mt[i] <= -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mt[i] < 0) begin
          if (start) begin
            mt[i]    <= 0;
            ds[i][0] <= int'(d) & dmask(i);
          end
        end else begin
          if (mt[i] < win(i) - 1) ds[i][mt[i] + 1] <= int'(d) & dmask(i);
          mt[i] <= (mt[i] == win(i) + sbits(i) + 1) ? -1 : mt[i] + 1;
        end
      end
    end
  end

  function automatic int model_sig(input int i);
    int m;
    int sb;
    m  = 0;
    sb = sbits(i);
    for (int k = 0; k < win(i); k++) begin
      m = ((m << 1) ^ ((((m >> (sb - 1)) & 1) != 0) ? poly(i) : 0) ^ ds[i][k]) & ((1 << sb) - 1);
    end
    return m;
  endfunction

  always @(negedge clk) begin
    int t, w, sb, eq;
    int eb, ev, ed;
    for (int i = 0; i < 3; i++) begin
      t  = mt[i];
      w  = win(i);
      sb = sbits(i);
      eb = (t >= 0 && t <= w + sb) ? 1 : 0;
      ev = (t > w && t <= w + sb) ? 1 : 0;
      ed = (t == w + sb + 1) ? 1 : 0;
      eq = (ev != 0) ? ((model_sig(i) >> (sb - 1 - (t - w - 1))) & 1) : 0;
      chk($sformatf("busy[%0d]", i), int'(busy_o[i]), eb);
      chk($sformatf("q_valid[%0d]", i), int'(qv_o[i]), ev);
      chk($sformatf("done[%0d]", i), int'(done_o[i]), ed);
      chk($sformatf("q[%0d]", i), int'(q_o[i]), eq);
    end
  end

  task automatic capture(input int ncyc, output int s0, output int s1, output int nb0,
                         output int nd0, output int nv0, output int fb0);
    s0 = 0; s1 = 0; nb0 = 0; nd0 = 0; nv0 = 0; fb0 = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (qv_o[0]) begin s0 = (s0 << 1) | int'(q_o[0]); nv0++; end
      if (qv_o[1]) s1 = (s1 << 1) | int'(q_o[1]);
      if (busy_o[0] && fb0 < 0) fb0 = k;
      nb0 += int'(busy_o[0]);
      nd0 += int'(done_o[0]);
    end
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while ((busy_o[0] || busy_o[1] || busy_o[2] || done_o[0] || done_o[1] || done_o[2]) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int s0, s1, nb0, nd0, nv0, fb0;
    int prev_b, b_first, d_first, b_second, nstarts, ndone, k;
    bit seen;

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_o[2]), 0);
    chk("reset_q_valid", int'(qv_o[2]), 0);
    chk("reset_done", int'(done_o[0]), 0);
    chk("reset_q", int'(q_o[0]), 0);

    // d held 1, start on the very first edge after reset release
    @(posedge clk); #3; resetn = 1'b1; start = 1'b1; d = 8'hFF;
    @(posedge clk); #3; start = 1'b0;
    capture(30, s0, s1, nb0, nd0, nv0, fb0);
    chk("first_edge_start", fb0, 0);
    chk("w4_sig_ones", s0, 'hF);
    chk("w5_sig_ones", s1, 'hC);
    chk("w4_busy_cycles", nb0, 9);
    chk("w4_valid_cycles", nv0, 4);
    chk("w4_done_pulses", nd0, 1);
    wait_idle(600);

    // d held 0
    @(posedge clk); #3; d = 8'h00; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
    capture(30, s0, s1, nb0, nd0, nv0, fb0);
    chk("w4_sig_zeros", s0, 0);
    chk("w4_busy_cycles_zero", nb0, 9);
    chk("w4_valid_cycles_zero", nv0, 4);
    wait_idle(600);

    // start held high across a whole run
    @(posedge clk); #3; d = 8'hFF; start = 1'b1;
    prev_b = 0; b_first = -1; d_first = -1; b_second = -1; nstarts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o[0] && prev_b == 0) begin
        nstarts++;
        if (b_first < 0) b_first = i; else if (b_second < 0) b_second = i;
      end
      if (done_o[0] && d_first < 0) d_first = i;
      prev_b = int'(busy_o[0]);
    end
    chk("held_first_busy", b_first, 1);
    chk("held_first_done", d_first, 10);
    chk("held_second_busy", b_second, 12);
    chk("held_run_starts", nstarts, 2);
    @(posedge clk); #3; start = 1'b0;
    wait_idle(700);

    // reset during SHIFT bit 2
    @(posedge clk); #3; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!qv_o[0] && k < 30) begin @(negedge clk); k++; end
    if (k >= 30) chk("shift_timeout", 1, 0);
    @(negedge clk);
    @(posedge clk); #3; resetn = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o[0]), 0);
    chk("abort_q_valid", int'(qv_o[0]), 0);
    chk("abort_q", int'(q_o[0]), 0);
    chk("abort_done", int'(done_o[0]), 0);
    capture(3, s0, s1, nb0, nd0, nv0, fb0);
    chk("abort_no_done", nd0, 0);
    @(posedge clk); #3; resetn = 1'b1; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
    capture(30, s0, s1, nb0, nd0, nv0, fb0);
    chk("post_reset_w4_sig", s0, 'hF);
    chk("post_reset_w5_sig", s1, 'hC);
    wait_idle(600);

    // random d, 100 runs on the default configuration
    ndone = 0;
    for (int r = 0; r < 100; r++) begin
      @(posedge clk); #3; start = 1'b1; d = 8'($urandom);
      @(posedge clk); #3; start = 1'b0; d = 8'($urandom);
      seen = 0;
      k = 0;
      while (!seen && k < 400) begin
        @(negedge clk);
        if (done_o[2]) seen = 1;
        @(posedge clk); #3; d = 8'($urandom);
        k++;
      end
      if (seen) ndone++;
      else chk("def_done_timeout", 0, 1);
    end
    chk("def_runs_done", ndone, 100);
    wait_idle(600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
